control_pila: RTL and testbench

- Call/return sequencer that drives the program stack (`pila`).
- It is the initiator side of the stack interface. It issues push/pop via `activa`/`push`/`entradaDatos` and consumes `salidaDatos`.
- On CALL it pushes PC+1 and redirects the PC to the target. On RET it takes the top of stack as the new PC and pops.
- It tracks stack depth and traps overflow and underflow.
- It sits between instruction decode and the PC register.

---
 rtl/control_pila_pkg.sv | 15 +
 rtl/contador_profundidad.sv | 61 ++++++
 rtl/control_pila.sv | 150 +++++++++++++++
 tb/tb_control_pila.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pila_pkg.sv
// Shared types and default sizing for the call/return sequencer.
package control_pila_pkg;

   // Sequencer states; encoding is fixed so it can be observed on debug buses.
   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      OPERACION = 2'd1,
      BLOQUEO   = 2'd2
   } estado_t;

   localparam int unsigned ANCHO_PC_DEF    = 8;
   localparam int unsigned PROFUNDIDAD_DEF = 511;
   localparam int unsigned ANCHO_PROF_DEF  = 9;

endpackage

// File: rtl/contador_profundidad.sv
// Stack depth counter with full/empty flags.
// Optional high-water mark enabled by CONTROL_PILA_MARCA_MAX_EN.
module contador_profundidad
   import control_pila_pkg::*;
#(
   parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF,
   parameter int unsigned ANCHO_PROF  = ANCHO_PROF_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  incrementa,
   input  logic                  decrementa,
   output logic [ANCHO_PROF-1:0] profundidad,
`ifdef CONTROL_PILA_MARCA_MAX_EN
   output logic [ANCHO_PROF-1:0] profundidad_max,
`endif
   output logic                  lleno,
   output logic                  vacio
);

   logic [ANCHO_PROF-1:0] cuenta_q, cuenta_d;

   // Next depth; the caller never asks to go past full or below empty.
   always_comb begin
      cuenta_d = cuenta_q;
      if (incrementa) begin
         cuenta_d = cuenta_q + ANCHO_PROF'(1);
      end else if (decrementa) begin
         cuenta_d = cuenta_q - ANCHO_PROF'(1);
      end
   end

   // Depth register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cuenta_q <= '0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign profundidad = cuenta_q;
   assign lleno       = (cuenta_q == ANCHO_PROF'(PROFUNDIDAD));
   assign vacio       = (cuenta_q == '0);

`ifdef CONTROL_PILA_MARCA_MAX_EN
   logic [ANCHO_PROF-1:0] maximo_q;

   // High-water mark follows the depth on the same edge; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         maximo_q <= '0;
      end else if (cuenta_d > maximo_q) begin
         maximo_q <= cuenta_d;
      end
   end

   assign profundidad_max = maximo_q;
`endif

endmodule

// File: rtl/control_pila.sv
// Call/return sequencer driving the program stack (initiator side).
// CALL pushes PC+1 and jumps to the target; RET loads top of stack and pops.
// Optional macro CONTROL_PILA_MARCA_MAX_EN adds the profundidad_max output.
module control_pila
   import control_pila_pkg::*;
#(
   parameter int unsigned ANCHO_PC    = ANCHO_PC_DEF,
   parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF,
   parameter int unsigned ANCHO_PROF  = ANCHO_PROF_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  llamada,
   input  logic                  retorno,
   input  logic [ANCHO_PC-1:0]   pc_actual,
   input  logic [ANCHO_PC-1:0]   destino,
   output logic [ANCHO_PC-1:0]   pc_siguiente,
   output logic                  carga_pc,
   output logic                  ocupado,
   output logic                  pila_activa,
   output logic                  pila_push,
   output logic [ANCHO_PC-1:0]   pila_datos_out,
   input  logic [ANCHO_PC-1:0]   pila_datos_in,
   output logic [ANCHO_PROF-1:0] profundidad,
`ifdef CONTROL_PILA_MARCA_MAX_EN
   output logic [ANCHO_PROF-1:0] profundidad_max,
`endif
   output logic                  desbordamiento,
   output logic                  subdesbordamiento
);

   estado_t estado_q, estado_d;

   logic [ANCHO_PC-1:0] pc_q, pc_d;
   logic [ANCHO_PC-1:0] datos_q, datos_d;
   logic                carga_q, carga_d;
   logic                activa_q, activa_d;
   logic                push_q, push_d;
   logic                ocupado_q, ocupado_d;
   logic                desb_q, desb_d;
   logic                subdesb_q, subdesb_d;
   logic                incrementa, decrementa;
   logic                lleno, vacio;

   contador_profundidad #(
      .PROFUNDIDAD (PROFUNDIDAD),
      .ANCHO_PROF  (ANCHO_PROF)
   ) u_contador (
      .clk             (clk),
      .reset           (reset),
      .incrementa      (incrementa),
      .decrementa      (decrementa),
      .profundidad     (profundidad),
`ifdef CONTROL_PILA_MARCA_MAX_EN
      .profundidad_max (profundidad_max),
`endif
      .lleno           (lleno),
      .vacio           (vacio)
   );

   // Next state and next registered outputs; strobes default low, data holds.
   always_comb begin
      estado_d   = estado_q;
      pc_d       = pc_q;
      datos_d    = datos_q;
      carga_d    = 1'b0;
      activa_d   = 1'b0;
      push_d     = 1'b0;
      desb_d     = desb_q;
      subdesb_d  = subdesb_q;
      incrementa = 1'b0;
      decrementa = 1'b0;
      unique case (estado_q)
         REPOSO: begin
            // llamada has priority; a simultaneous retorno is dropped.
            if (llamada) begin
               if (!lleno) begin
                  activa_d   = 1'b1;
                  push_d     = 1'b1;
                  datos_d    = pc_actual + ANCHO_PC'(1);
                  pc_d       = destino;
                  carga_d    = 1'b1;
                  incrementa = 1'b1;
                  estado_d   = OPERACION;
               end else begin
                  desb_d   = 1'b1;
                  estado_d = BLOQUEO;
               end
            end else if (retorno) begin
               if (!vacio) begin
                  activa_d   = 1'b1;
                  pc_d       = pila_datos_in;
                  carga_d    = 1'b1;
                  decrementa = 1'b1;
                  estado_d   = OPERACION;
               end else begin
                  subdesb_d = 1'b1;
                  estado_d  = BLOQUEO;
               end
            end
         end
         OPERACION: begin
            // Stack acts on the edge that closes this cycle.
            estado_d = REPOSO;
         end
         BLOQUEO: begin
            estado_d = BLOQUEO;
         end
         default: begin
            estado_d = REPOSO;
         end
      endcase
      ocupado_d = (estado_d != REPOSO);
   end

   // State and output registers; reset drops any pending strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q  <= REPOSO;
         pc_q      <= '0;
         datos_q   <= '0;
         carga_q   <= 1'b0;
         activa_q  <= 1'b0;
         push_q    <= 1'b0;
         ocupado_q <= 1'b0;
         desb_q    <= 1'b0;
         subdesb_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         pc_q      <= pc_d;
         datos_q   <= datos_d;
         carga_q   <= carga_d;
         activa_q  <= activa_d;
         push_q    <= push_d;
         ocupado_q <= ocupado_d;
         desb_q    <= desb_d;
         subdesb_q <= subdesb_d;
      end
   end

   assign pc_siguiente      = pc_q;
   assign carga_pc          = carga_q;
   assign ocupado           = ocupado_q;
   assign pila_activa       = activa_q;
   assign pila_push         = push_q;
   assign pila_datos_out    = datos_q;
   assign desbordamiento    = desb_q;
   assign subdesbordamiento = subdesb_q;

endmodule

// File: tb/tb_control_pila.sv
// Scoreboard bench for control_pila with a behavioural stack model.
module tb_control_pila;

   logic       clk = 1'b0;
   logic       reset;
   logic       llamada, retorno;
   logic [7:0] pc_actual, destino;
   logic [7:0] pc_siguiente;
   logic       carga_pc, ocupado, pila_activa, pila_push;
   logic [7:0] pila_datos_out;
   logic [7:0] pila_datos_in;
   logic [8:0] profundidad;
   logic       desbordamiento, subdesbordamiento;
`ifdef CONTROL_PILA_MARCA_MAX_EN
   logic [8:0] profundidad_max;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] pc;
      logic       push;
      logic [7:0] datos;
      logic [8:0] prof;
   } esperado_t;

   esperado_t sb[$];

   control_pila dut (
      .clk               (clk),
      .reset             (reset),
      .llamada           (llamada),
      .retorno           (retorno),
      .pc_actual         (pc_actual),
      .destino           (destino),
      .pc_siguiente      (pc_siguiente),
      .carga_pc          (carga_pc),
      .ocupado           (ocupado),
      .pila_activa       (pila_activa),
      .pila_push         (pila_push),
      .pila_datos_out    (pila_datos_out),
      .pila_datos_in     (pila_datos_in),
      .profundidad       (profundidad),
`ifdef CONTROL_PILA_MARCA_MAX_EN
      .profundidad_max   (profundidad_max),
`endif
      .desbordamiento    (desbordamiento),
      .subdesbordamiento (subdesbordamiento)
   );

   always #5 clk = ~clk;

   // Behavioural stack: word 0 is never written, top is registered.
   logic [7:0] mem [512];
   int         sp;
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      sp = 0;
      pila_datos_in = 8'h00;
   end
   always @(posedge clk) begin
      if (reset) begin
         sp <= 0;
         pila_datos_in <= 8'h00;
      end else if (pila_activa) begin
         if (pila_push) begin
            mem[sp + 1] <= pila_datos_out;
            pila_datos_in <= pila_datos_out;
            sp <= sp + 1;
         end else begin
            pila_datos_in <= mem[(sp + 511) % 512];
            sp <= sp - 1;
         end
      end
   end

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nombre, act, req);
      end
   endtask

   // Monitor: every carga_pc must match the oldest expected transaction.
   always @(negedge clk) begin
      if (carga_pc === 1'b1) begin
         if (sb.size() == 0) begin
            chk("carga_inesperada", 32'(carga_pc), 32'd0);
         end else begin
            esperado_t e;
            e = sb.pop_front();
            chk("pc_siguiente", 32'(pc_siguiente), 32'(e.pc));
            chk("pila_push", 32'(pila_push), 32'(e.push));
            chk("pila_activa", 32'(pila_activa), 32'd1);
            chk("ocupado_op", 32'(ocupado), 32'd1);
            chk("profundidad_op", 32'(profundidad), 32'(e.prof));
            if (e.push) chk("pila_datos_out", 32'(pila_datos_out), 32'(e.datos));
         end
      end
   end

   task automatic aplicar_reset();
      reset = 1'b1;
      llamada = 1'b0;
      retorno = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic chk_reposo(input string etapa);
      chk({etapa, "_pc"}, 32'(pc_siguiente), 32'd0);
      chk({etapa, "_carga"}, 32'(carga_pc), 32'd0);
      chk({etapa, "_ocupado"}, 32'(ocupado), 32'd0);
      chk({etapa, "_activa"}, 32'(pila_activa), 32'd0);
      chk({etapa, "_push"}, 32'(pila_push), 32'd0);
      chk({etapa, "_datos"}, 32'(pila_datos_out), 32'd0);
      chk({etapa, "_prof"}, 32'(profundidad), 32'd0);
      chk({etapa, "_desb"}, 32'(desbordamiento), 32'd0);
      chk({etapa, "_subdesb"}, 32'(subdesbordamiento), 32'd0);
   endtask

   task automatic llamar(input logic [7:0] pc, input logic [7:0] dst,
                         input logic [7:0] datos_esp, input logic [8:0] prof_esp);
      sb.push_back('{pc: dst, push: 1'b1, datos: datos_esp, prof: prof_esp});
      pc_actual = pc;
      destino   = dst;
      llamada   = 1'b1;
      @(posedge clk);
      #1 llamada = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic retornar(input logic [7:0] pc_esp, input logic [8:0] prof_esp);
      sb.push_back('{pc: pc_esp, push: 1'b0, datos: 8'h00, prof: prof_esp});
      retorno = 1'b1;
      @(posedge clk);
      #1 retorno = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Request that must not be accepted; nothing goes on the scoreboard.
   task automatic pedir_rechazada(input logic ll, input logic rt);
      llamada = ll;
      retorno = rt;
      @(posedge clk);
      #1 llamada = 1'b0;
      retorno = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pc_actual = 8'h00;
      destino   = 8'h00;
      aplicar_reset();
      chk_reposo("reset");
`ifdef CONTROL_PILA_MARCA_MAX_EN
      chk("max_reset", 32'(profundidad_max), 32'd0);
`endif

      // Single call then return.
      llamar(8'h10, 8'h40, 8'h11, 9'd1);
      chk("ocupado_tras_op", 32'(ocupado), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      retornar(8'h11, 9'd0);

      // Nested calls and returns.
      llamar(8'h10, 8'h40, 8'h11, 9'd1);
      llamar(8'h20, 8'h50, 8'h21, 9'd2);
      llamar(8'h30, 8'h60, 8'h31, 9'd3);
      retornar(8'h31, 9'd2);
      retornar(8'h21, 9'd1);
      retornar(8'h11, 9'd0);
      chk("prof_anidado", 32'(profundidad), 32'd0);
`ifdef CONTROL_PILA_MARCA_MAX_EN
      chk("max_anidado", 32'(profundidad_max), 32'd3);
`endif

      // Underflow locks the sequencer until reset.
      pedir_rechazada(1'b0, 1'b1);
      chk("subdesb", 32'(subdesbordamiento), 32'd1);
      chk("subdesb_activa", 32'(pila_activa), 32'd0);
      chk("subdesb_carga", 32'(carga_pc), 32'd0);
      chk("subdesb_ocupado", 32'(ocupado), 32'd1);
      pedir_rechazada(1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("bloqueo_carga", 32'(carga_pc), 32'd0);
      chk("bloqueo_ocupado", 32'(ocupado), 32'd1);
      chk("bloqueo_prof", 32'(profundidad), 32'd0);
      chk("bloqueo_desb", 32'(desbordamiento), 32'd0);
      aplicar_reset();
      chk_reposo("reset2");

      // PC+1 wraps; then llamada beats retorno.
      llamar(8'hFF, 8'h00, 8'h00, 9'd1);
      llamar(8'h05, 8'h80, 8'h06, 9'd2);
      sb.push_back('{pc: 8'h90, push: 1'b1, datos: 8'h08, prof: 9'd3});
      pc_actual = 8'h07;
      destino   = 8'h90;
      llamada   = 1'b1;
      retorno   = 1'b1;
      @(posedge clk);
      #1 llamada = 1'b0;
      retorno = 1'b0;
      @(posedge clk);
      #1;
      chk("simultanea_prof", 32'(profundidad), 32'd3);

      // Reset during the OPERACION cycle.
      sb.push_back('{pc: 8'h70, push: 1'b1, datos: 8'h21, prof: 9'd4});
      pc_actual = 8'h20;
      destino   = 8'h70;
      llamada   = 1'b1;
      @(posedge clk);
      #1 llamada = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk_reposo("reset_op");
      llamar(8'h00, 8'h33, 8'h01, 9'd1);

      // Fill to 511 entries, then overflow.
      aplicar_reset();
      for (int i = 0; i < 511; i++) begin
         llamar(8'(i), 8'hA5, 8'(i + 1), 9'(i + 1));
      end
      chk("lleno_prof", 32'(profundidad), 32'd511);
      pedir_rechazada(1'b1, 1'b0);
      chk("desb", 32'(desbordamiento), 32'd1);
      chk("desb_prof", 32'(profundidad), 32'd511);
      chk("desb_activa", 32'(pila_activa), 32'd0);
      chk("desb_push", 32'(pila_push), 32'd0);
      chk("desb_carga", 32'(carga_pc), 32'd0);
      chk("desb_ocupado", 32'(ocupado), 32'd1);
`ifdef CONTROL_PILA_MARCA_MAX_EN
      chk("max_lleno", 32'(profundidad_max), 32'd511);
`endif
      @(posedge clk);
      #1;
      chk("cola_vacia", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
